// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the serial run-of-ones scanner.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_state_t;

    localparam int unsigned RUN_LEN = 4;

endpackage

// File: rtl/run_det.sv
// Mealy detector for RUN_LEN consecutive 1s; state persists until clr or rst.
// SEQ_SCAN_OVERLAP_EN selects overlapping detection (stay in last state after a match).
module run_det
    import seq_scan_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic z
);

    localparam det_state_t ST_LAST = det_state_t'(2'(RUN_LEN - 1));

    det_state_t st;

    assign z = en && bit_in && (st == ST_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= S0;
        end else if (clr) begin
            st <= S0;
        end else if (en) begin
            if (!bit_in) begin
                st <= S0;
            end else if (st == ST_LAST) begin
`ifdef SEQ_SCAN_OVERLAP_EN
                st <= ST_LAST;
`else
                st <= S0;
`endif
            end else begin
                st <= det_state_t'(st + 2'd1);
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts a word, shifts it MSB first through run_det and reports the saturating match count.
// Detection mode set by SEQ_SCAN_OVERLAP_EN (see run_det).
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_hit,
    output logic              busy
);

    localparam int unsigned       IDX_W    = $clog2(WORD_W);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    ctrl_state_t       state;
    logic [WORD_W-1:0] sh;
    logic [IDX_W-1:0]  idx;
    logic              drain;
    logic              match_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              det_clr;
    logic              det_en;
    logic              det_z;

    // flush only acts in IDLE; the drain cycle folds in the last registered match
    assign det_clr = (state == IDLE) && flush;
    assign det_en  = (state == SHIFT) && !drain;
    assign cnt_inc = (match_q && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;

    run_det u_det (
        .clk    (clk),
        .rst    (rst),
        .clr    (det_clr),
        .en     (det_en),
        .bit_in (sh[WORD_W-1]),
        .z      (det_z)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sh        <= '0;
            idx       <= '0;
            drain     <= 1'b0;
            match_q   <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_count <= '0;
            out_hit   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            match_q <= det_z;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh       <= in_data;
                        idx      <= IDX_LAST;
                        cnt      <= '0;
                        drain    <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt_inc;
                    if (drain) begin
                        out_count <= cnt_inc;
                        out_hit   <= (cnt_inc != '0);
                        out_valid <= 1'b1;
                        drain     <= 1'b0;
                        state     <= REPORT;
                    end else begin
                        sh  <= {sh[WORD_W-2:0], 1'b0};
                        idx <= idx - IDX_W'(1);
                        if (idx == '0) begin
                            drain <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed cases plus random words against a run-length model.
module tb_seq_scan_ctrl;

`ifdef SEQ_SCAN_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, out_hit, busy;
    logic [3:0] out_count;
    logic       in_ready2, out_valid2, out_hit2, busy2;
    logic [1:0] out_count2;

    int n_checks = 0;
    int n_pass   = 0;
    int ones     = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.WORD_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_hit(out_hit), .busy(busy)
    );

    seq_scan_ctrl #(.WORD_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready), .out_count(out_count2),
        .out_hit(out_hit2), .busy(busy2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Model: length of the current run of 1s; a match every time the run reaches RUN_LEN
    function automatic int model_scan(input logic [7:0] d);
        int m = 0;
        for (int i = 7; i >= 0; i--) begin
            if (d[i]) begin
                ones++;
                if (ones >= 4) begin
                    m++;
                    if (!OVL) ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        return m;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic idle_cycles(input int n, input bit fl);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            flush = fl;
            @(posedge clk);
            if (fl) ones = 0;
        end
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit fl, input int hold, input int exp_fixed);
        int m;
        int k;
        logic [3:0] held;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        check("ready_wait", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        @(posedge clk);
        if (fl) ones = 0;
        m = model_scan(d);
        #1;
        in_valid = 1'b0;
        flush    = 1'($urandom_range(0, 1));
        check("busy_after_accept", int'(busy), 1);
        check("in_ready_after_accept", int'(in_ready), 0);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", k, 9);
        check("out_count", int'(out_count), sat(m, 15));
        check("out_hit", int'(out_hit), int'(m != 0));
        check("out_count_cnt2", int'(out_count2), sat(m, 3));
        check("out_valid_cnt2", int'(out_valid2), 1);
        if (exp_fixed >= 0) check("out_count_directed", int'(out_count), exp_fixed);
        held = out_count;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            @(posedge clk);
            #1;
            check("hold_valid", int'(out_valid), 1);
            check("hold_count", int'(out_count), int'(held));
            check("hold_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_dropped", int'(out_valid), 0);
        check("idle_not_busy", int'(busy), 0);
    endtask

    initial begin
        int saw;
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_out_hit", int'(out_hit), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        ones = 0;

        send(8'hFF, 1'b1, 0, OVL ? 5 : 2);
        send(8'h0F, 1'b1, 0, 1);
        send(8'hF0, 1'b0, 0, OVL ? 4 : 1);
        send(8'h0F, 1'b1, 0, 1);
        idle_cycles(2, 1'b1);
        send(8'hF0, 1'b0, 0, 1);
        send(8'hFF, 1'b1, 5, OVL ? 5 : 2);

        // reset in the middle of a word: no result, detector back to S0
        send(8'h00, 1'b1, 0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hF0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_count", int'(out_count), 0);
        check("midrst_out_hit", int'(out_hit), 0);
        check("midrst_busy", int'(busy), 0);
        @(negedge clk);
        rst  = 1'b0;
        ones = 0;
        saw  = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw = 1;
        end
        check("midrst_no_result", saw, 0);
        send(8'h0F, 1'b0, 0, 1);

        for (int w = 0; w < 30; w++) begin
            idle_cycles($urandom_range(0, 2), 1'($urandom_range(0, 1)));
            send(8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 2), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
